// File: rtl/quad_pkg.sv
// Shared phase, state and direction definitions for the quadrature front end.
package quad_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_01 = 2'b01;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_10 = 2'b10;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Successor of a phase in the forward Gray sequence 00 -> 01 -> 11 -> 10 -> 00.
  function automatic phase_t fwd_of(input phase_t ph);
    case (ph)
      PH_00:   fwd_of = PH_01;
      PH_01:   fwd_of = PH_11;
      PH_11:   fwd_of = PH_10;
      default: fwd_of = PH_00;
    endcase
  endfunction

  // Whether a valid single-bit step produces a count at the given resolution.
  function automatic logic step_counts(input phase_t from_ph, input phase_t to_ph,
                                       input logic up, input int unsigned res);
    case (res)
      4:       step_counts = 1'b1;
      2:       step_counts = (from_ph[1] != to_ph[1]);
      default: step_counts = up ? (from_ph == PH_10 && to_ph == PH_00)
                                : (from_ph == PH_00 && to_ph == PH_10);
    endcase
  endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// Per-channel 2-FF synchroniser followed by a stability filter: a new level is
// accepted only after it has been seen unchanged for FILTER_LEN+1 cycles.
module quad_sync_filter #(
  parameter int unsigned FILTER_LEN = 2
) (
  input  logic Clock,
  input  logic Sclr_n,
  input  logic Raw,
  output logic Stable
);

  if (FILTER_LEN > 15) begin : g_bad_filter_len
    $error("quad_sync_filter: FILTER_LEN must be in 0..15");
  end

  localparam logic [3:0] FL_C = 4'(FILTER_LEN);

  logic       sync1;
  logic       sync2;
  logic [3:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (!Sclr_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      Stable <= 1'b0;
    end else begin
      sync1 <= Raw;
      sync2 <= sync1;
      // Acceptance wins over restart: a level that just completed its run is kept.
      if (sync2 != Stable && cnt == FL_C) begin
        Stable <= sync2;
        cnt    <= '0;
      end else if (sync1 != sync2 || sync2 == Stable) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/quad_decoder_16.sv
// Quadrature decoder front end driving a 16-bit up/down counter via Cnt_En/UpDown.
// Optional index support (Z input, Index_Clr output) is enabled by defining QUAD_INDEX_EN.
module quad_decoder_16 #(
  parameter int unsigned FILTER_LEN = 2,
  parameter int unsigned RESOLUTION = 4,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             Clock,
  input  logic             Sclr_n,
  input  logic             A,
  input  logic             B,
`ifdef QUAD_INDEX_EN
  input  logic             Z,
  output logic             Index_Clr,
`endif
  input  logic             Err_Clr,
  output logic             Cnt_En,
  output logic             UpDown,
  output logic             Dir,
  output logic             Err,
  output logic [ERR_W-1:0] Err_Cnt
);
  import quad_pkg::*;

  if (RESOLUTION != 1 && RESOLUTION != 2 && RESOLUTION != 4) begin : g_bad_resolution
    $error("quad_decoder_16: RESOLUTION must be 1, 2 or 4");
  end

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic   a_f;
  logic   b_f;
  phase_t f;
  phase_t phase_q;
  phase_t phase_d;
  state_t state_q;
  state_t state_d;
  logic   step_valid;
  logic   step_up;
  logic   step_err;
  logic   cnt_en_d;
  logic   index_d;

  quad_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .Clock (Clock),
    .Sclr_n(Sclr_n),
    .Raw   (A),
    .Stable(a_f)
  );

  quad_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .Clock (Clock),
    .Sclr_n(Sclr_n),
    .Raw   (B),
    .Stable(b_f)
  );

  assign f = {a_f, b_f};

`ifdef QUAD_INDEX_EN
  logic z_f;

  quad_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_z (
    .Clock (Clock),
    .Sclr_n(Sclr_n),
    .Raw   (Z),
    .Stable(z_f)
  );
`endif

  // State register, stored phase and registered outputs.
  always_ff @(posedge Clock) begin
    if (!Sclr_n) begin
      state_q <= INIT;
      phase_q <= PH_00;
      Cnt_En  <= 1'b0;
      UpDown  <= 1'b0;
      Dir     <= 1'b0;
      Err     <= 1'b0;
      Err_Cnt <= '0;
`ifdef QUAD_INDEX_EN
      Index_Clr <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      Cnt_En  <= cnt_en_d;
      Err     <= step_err;
      if (cnt_en_d) begin
        UpDown <= step_up;
        Dir    <= step_up;
      end
      if (Err_Clr) begin
        Err_Cnt <= '0;
      end else if (Err && Err_Cnt != ERR_MAX) begin
        Err_Cnt <= Err_Cnt + ERR_W'(1);
      end
`ifdef QUAD_INDEX_EN
      Index_Clr <= index_d;
`endif
    end
  end

  // Next state: INIT latches the filtered phase once; TRACK follows every change,
  // legal or not, so an illegal jump resynchronises instead of cascading errors.
  always_comb begin
    state_d = TRACK;
    phase_d = f;
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    step_valid = 1'b0;
    step_up    = DIR_DN;
    step_err   = 1'b0;
    if (state_q == TRACK && f != phase_q) begin
      if (f == fwd_of(phase_q)) begin
        step_valid = 1'b1;
        step_up    = DIR_UP;
      end else if (phase_q == fwd_of(f)) begin
        step_valid = 1'b1;
        step_up    = DIR_DN;
      end else begin
        step_err = 1'b1;
      end
    end
    cnt_en_d = step_valid && step_counts(phase_q, f, step_up, RESOLUTION);
`ifdef QUAD_INDEX_EN
    index_d  = step_valid && (f == PH_00) && z_f;
`else
    index_d  = 1'b0;
`endif
  end

endmodule

// File: doc/quad_decoder_16.md
Name: quad_decoder_16

Overview:
Quadrature front end for the 16-bit up/down counter. It samples asynchronous encoder channels A/B, synchronises and glitch-filters them, and tracks the Gray-code phase with a small FSM. For each valid step it emits a one-cycle Cnt_En pulse with a matching UpDown level, which drive the counter's Cnt_En/UpDown inputs directly. Illegal double steps are flagged and counted, not forwarded.

Parameters:
FILTER_LEN, 2, cycles a synchronised A/B value must be stable before acceptance; 0 = bypass filter; legal 0..15
RESOLUTION, 4, counts per encoder cycle; legal 1, 2, 4; other values are a compile-time error
ERR_W, 8, width of the saturating error counter

Ports:
Clock  in  1  single system clock, rising edge
Sclr_n  in  1  synchronous active-low reset
A  in  1  encoder channel A, asynchronous
B  in  1  encoder channel B, asynchronous
Err_Clr  in  1  synchronous clear of Err_Cnt
Cnt_En  out  1  one-cycle count pulse to the counter
UpDown  out  1  direction for the counter: 1 = up, 0 = down; valid whenever Cnt_En = 1
Dir  out  1  last valid direction, held
Err  out  1  one-cycle illegal-transition pulse
Err_Cnt  out  ERR_W  saturating count of illegal transitions

Behaviour:
- Reset: one clock and one reset only. Reset is synchronous and active-low on Sclr_n, sampled on the rising edge of Clock. While Sclr_n = 0: sync flops, filter counter, Cnt_En, UpDown, Dir, Err and Err_Cnt all = 0; FSM = INIT. Reset mid-step discards any pending filter qualification.
- Sync: 2-FF synchroniser per channel, giving the pair s = {A_s, B_s}.
- Filter: when s differs from the accepted value f, a counter increments each cycle s stays stable. f <= s when the count reaches FILTER_LEN. Any change of s restarts the count. FILTER_LEN = 0 gives f <= s every cycle.
- Phase encoding: {A,B}. Forward sequence 00 -> 01 -> 11 -> 10 -> 00; reverse is the opposite order.
- FSM:
  - INIT: on the first cycle after reset release, latch f as the phase; no count, no Err; go to TRACK.
  - TRACK: evaluate each change of f against the stored phase.
    - Single-bit change, forward: counts per the RESOLUTION rule below.
    - Single-bit change, reverse: same rule, mirrored.
    - Both bits change: Err = 1, no count, phase <= f.
    - No change: idle.
- RESOLUTION rule:
  - 4: every valid step counts.
  - 2: only A-edge steps count: forward 01->11 and 10->00; reverse 11->01 and 00->10.
  - 1: forward 10->00 only; reverse 00->10 only.
- Outputs are registered.
  - On a counted step: Cnt_En = 1 and UpDown = direction, both for exactly one cycle; Dir <= direction.
  - UpDown holds its last value when Cnt_En = 0.
- Latency: an A/B edge first captured at Clock edge k gives Cnt_En high in cycle k+3+FILTER_LEN. Maximum step rate is one step per FILTER_LEN+1 cycles; faster input is filtered away, not counted.
- Err_Cnt: increments on Err and saturates at 2^ERR_W-1. Err_Clr has priority: Err_Clr and Err in the same cycle gives Err_Cnt = 0. Err still pulses.
- Direction reversal between consecutive steps is legal and produces opposite UpDown on consecutive pulses.

Optional Feature:
Macro QUAD_INDEX_EN.
- Defined: adds input Z (index, asynchronous; synchronised and filtered the same way as A/B) and output Index_Clr.
- Index_Clr pulses for one cycle, aligned with the cycle in which a Cnt_En would appear, when filtered Z = 1 and the phase enters 00. It is intended to drive the counter's Sclr. When Index_Clr and Cnt_En coincide, both are asserted and the counter's Sclr priority resolves the conflict.
- Undefined: ports Z and Index_Clr are absent; no index logic.

Decomposition:
- Package quad_pkg holds:
  - phase constants PH_00, PH_01, PH_11, PH_10;
  - FSM state enum INIT/TRACK;
  - direction constants DIR_UP = 1, DIR_DN = 0.
- One natural sub-module: quad_sync_filter, a per-channel 2-FF synchroniser plus stability filter parameterised by FILTER_LEN. It is instantiated for A, B and, when enabled, Z.

Test Plan:
- Reset then idle, A = B = 0, FILTER_LEN = 2: all outputs 0; after release no Cnt_En and no Err.
- RESOLUTION = 4, one full forward cycle 00->01->11->10->00, each phase held 10 cycles: exactly 4 Cnt_En pulses, all with UpDown = 1, the first at cycle k+5; Dir = 1.
- RESOLUTION = 1, two reverse cycles: exactly 2 pulses, both with UpDown = 0. RESOLUTION = 2, one forward cycle: exactly 2 pulses.
- Glitch on A shorter than FILTER_LEN+1 cycles: no Cnt_En, no Err.
- Jump 00->11 repeated 300 times: 300 Err pulses, Err_Cnt = 255 (saturated); Err_Clr asserted in the same cycle as an Err gives Err_Cnt = 0.
- QUAD_INDEX_EN defined, Z = 1 during forward entry into 00: Index_Clr and Cnt_En both pulse in the same cycle; with Z = 0, no Index_Clr.
